// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
//   Shared types and constants for the HD44780 LCD bus controller:
//     - lcd_state_e : controller FSM states
//     - lcd_cmd_t   : one bus write (register select + data byte)
//     - bit positions of the fields inside the LSU LCD I/O register
//     - INIT_ROM    : 8-bit mode init sequence issued after power-up
//     - is_long_cmd : selects the long execution wait (clear / return home)
// -----------------------------------------------------------------------------
package lcd_pkg;

  localparam int TIMER_W = 20;

  localparam int LCD_ON_BIT  = 31;
  localparam int LCD_REQ_BIT = 30;
  localparam int LCD_RS_BIT  = 9;

  typedef enum logic [2:0] {
    PWRUP,
    IDLE,
    SETUP,
    EN_HI,
    HOLD,
    WAIT
  } lcd_state_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_cmd_t;

  // Function set 8-bit/2-line, display on, clear, entry mode increment.
  localparam int INIT_LEN = 4;
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data inside {8'h01, 8'h02, 8'h03});
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// -----------------------------------------------------------------------------
// lcd_timer
//   Zero-based down counter shared by every controller state. Loading T-1
//   keeps the caller in its state for exactly T cycles: o_done is high in the
//   last of them, and the counter rests at zero until reloaded.
// Ports
//   i_clk    clock
//   i_reset  asynchronous active-high reset (counter := RST_VAL)
//   i_load   load i_val this cycle
//   i_val    reload value (cycles - 1)
//   o_done   counter is zero
// -----------------------------------------------------------------------------
module lcd_timer
  import lcd_pkg::*;
#(
  parameter logic [TIMER_W-1:0] RST_VAL = '0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_val,
  output logic               o_done
);

  logic [TIMER_W-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the values present before the clock edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count <= RST_VAL;
    end else if (i_load) begin
      count <= i_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign o_done = (count == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_ctrl
//   Turns writes to the LSU LCD I/O register into HD44780 bus writes with the
//   controller timing enforced in hardware. After reset it waits for the panel
//   to power up, runs the 8-bit init sequence, then issues one bus write per
//   toggle of the REQ bit. One request can be held while a write is in flight;
//   further requests are dropped and flagged on o_ovf.
// Ports
//   i_clk       clock
//   i_reset     asynchronous active-high reset
//   i_io_lcd    [31] ON, [30] REQ toggle, [9] RS, [7:0] DATA
//   o_lcd_on    registered copy of i_io_lcd[31]
//   o_lcd_en    HD44780 E strobe
//   o_lcd_rs    register select (0 command, 1 data)
//   o_lcd_rw    always 0 (write only)
//   o_lcd_data  data bus
//   o_busy      controller not idle, or a request is held
//   o_ovf       sticky: a request was dropped
// -----------------------------------------------------------------------------
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWRUP_CYC = 750000,
  parameter int unsigned T_AS_CYC    = 2,
  parameter int unsigned T_EN_CYC    = 12,
  parameter int unsigned T_AH_CYC    = 2,
  parameter int unsigned T_CMD_CYC   = 2000,
  parameter int unsigned T_CLR_CYC   = 82000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_io_lcd,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data,
  output logic        o_busy,
  output logic        o_ovf
);

  // Timer reload values: a state lasting T cycles loads T-1.
  localparam logic [TIMER_W-1:0] LD_PWRUP = TIMER_W'(T_PWRUP_CYC - 1);
  localparam logic [TIMER_W-1:0] LD_AS    = TIMER_W'(T_AS_CYC - 1);
  localparam logic [TIMER_W-1:0] LD_EN    = TIMER_W'(T_EN_CYC - 1);
  localparam logic [TIMER_W-1:0] LD_AH    = TIMER_W'(T_AH_CYC - 1);
  localparam logic [TIMER_W-1:0] LD_CMD   = TIMER_W'(T_CMD_CYC - 1);
  localparam logic [TIMER_W-1:0] LD_CLR   = TIMER_W'(T_CLR_CYC - 1);

  lcd_state_e         state_q, state_d;
  logic               req_q;
  lcd_cmd_t           cur_q, cur_d;
  lcd_cmd_t           pend_q, pend_d;
  logic               pend_valid_q, pend_valid_d;
  logic [2:0]         init_idx_q, init_idx_d;
  logic               ovf_q, ovf_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               lcd_on_q;

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_done;

  logic               req_evt;
  lcd_cmd_t           evt_cmd;
  logic               take_pend;
  logic               direct;

  // Only ON, REQ, RS and DATA are meaningful in the I/O register.
  logic unused_io;
  assign unused_io = ^{i_io_lcd[29:10], i_io_lcd[8]};

  assign req_evt = i_io_lcd[LCD_REQ_BIT] ^ req_q;
  assign evt_cmd = '{rs: i_io_lcd[LCD_RS_BIT], data: i_io_lcd[7:0]};

  lcd_timer #(
    .RST_VAL (LD_PWRUP)
  ) u_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (tmr_load),
    .i_val   (tmr_val),
    .o_done  (tmr_done)
  );

  // State and datapath registers. Outputs are registered so the LCD pins
  // never see decode glitches, and reset drops them all at once.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= PWRUP;
      req_q        <= 1'b0;
      cur_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      init_idx_q   <= '0;
      ovf_q        <= 1'b0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      lcd_on_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= i_io_lcd[LCD_REQ_BIT];
      cur_q        <= cur_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      init_idx_q   <= init_idx_d;
      ovf_q        <= ovf_d;
      en_q         <= en_d;
      busy_q       <= busy_d;
      lcd_on_q     <= i_io_lcd[LCD_ON_BIT];
    end
  end

  // Next state, timer reloads, command selection and pending buffer.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    cur_d      = cur_q;
    init_idx_d = init_idx_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    take_pend  = 1'b0;
    direct     = 1'b0;

    unique case (state_q)
      PWRUP: begin
        if (tmr_done) begin
          state_d    = SETUP;
          cur_d      = '{rs: 1'b0, data: INIT_ROM[0]};
          init_idx_d = 3'd1;
          tmr_load   = 1'b1;
          tmr_val    = LD_AS;
        end
      end
      IDLE: begin
        if (pend_valid_q) begin
          state_d   = SETUP;
          cur_d     = pend_q;
          take_pend = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = LD_AS;
        end else if (req_evt) begin
          state_d  = SETUP;
          cur_d    = evt_cmd;
          direct   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = LD_AS;
        end
      end
      SETUP: begin
        if (tmr_done) begin
          state_d  = EN_HI;
          tmr_load = 1'b1;
          tmr_val  = LD_EN;
        end
      end
      EN_HI: begin
        if (tmr_done) begin
          state_d  = HOLD;
          tmr_load = 1'b1;
          tmr_val  = LD_AH;
        end
      end
      HOLD: begin
        if (tmr_done) begin
          state_d  = WAIT;
          tmr_load = 1'b1;
          tmr_val  = is_long_cmd(cur_q.rs, cur_q.data) ? LD_CLR : LD_CMD;
        end
      end
      WAIT: begin
        if (tmr_done) begin
          if (init_idx_q < 3'(INIT_LEN)) begin
            state_d    = SETUP;
            cur_d      = '{rs: 1'b0, data: INIT_ROM[init_idx_q[1:0]]};
            init_idx_d = init_idx_q + 3'd1;
            tmr_load   = 1'b1;
            tmr_val    = LD_AS;
          end else if (pend_valid_q) begin
            state_d   = SETUP;
            cur_d     = pend_q;
            take_pend = 1'b1;
            tmr_load  = 1'b1;
            tmr_val   = LD_AS;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d  = PWRUP;
        tmr_load = 1'b1;
        tmr_val  = LD_PWRUP;
      end
    endcase

    // A request not consumed directly goes to the pending slot. Draining
    // the slot this cycle frees it for a request arriving on the same edge.
    pend_valid_d = pend_valid_q & ~take_pend;
    pend_d       = pend_q;
    ovf_d        = ovf_q;
    if (req_evt && !direct) begin
      if (!pend_valid_d) begin
        pend_valid_d = 1'b1;
        pend_d       = evt_cmd;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // Output decode from the next state, registered alongside it.
  always_comb begin
    en_d   = (state_d == EN_HI);
    busy_d = (state_d != IDLE) || pend_valid_d;
  end

  assign o_lcd_on   = lcd_on_q;
  assign o_lcd_en   = en_q;
  assign o_lcd_rs   = cur_q.rs;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_data = cur_q.data;
  assign o_busy     = busy_q;
  assign o_ovf      = ovf_q;

endmodule
